reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Arbitrates the single write port of the shared 8-bit register bank between the I2C
//  slave write path and NREQ on-chip requesters (status/sensor logic). I2C writes cannot
//  stall, so they always win. Local requesters share the remaining slots round-robin via
//  a req/gnt handshake. A per-address mask blocks local writes to host-owned registers.
// PARAMETERS
//  NREQ        3              number of local requesters (1..8)
//  REGCOUNT    32             registers in bank; address width ADDR_W = $clog2(REGCOUNT)
//  LOCAL_WMASK {REGCOUNT{1'b1}} bit k = 1: local requesters may write register k
// PORTS
//  clock      in  1            system clock, all state on rising edge
//  reset      in  1            asynchronous, active-low; clears all state
//  i2c_we     in  1            one-cycle write strobe from the I2C slave
//  i2c_addr   in  ADDR_W       I2C target register
//  i2c_data   in  8            I2C write data
//  req        in  NREQ         local write requests, level, one bit per requester
//  req_addr   in  NREQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
//  req_data   in  NREQ*8       packed data; requester i at [i*8 +: 8]
//  gnt        out NREQ         one-hot, one-cycle pulse; requester i's request retired
//  err        out NREQ         one-cycle pulse with gnt; the write was suppressed (masked/range)
//  wr_en      out 1            register-bank write enable (registered)
//  wr_addr    out ADDR_W       register-bank write address (registered)
//  wr_data    out 8            register-bank write data (registered)
//  defer_cnt  out 8            saturating count of local requests deferred by I2C writes
// BEHAVIOUR
//  - Reset (reset=0, async): wr_en=0, wr_addr=0, wr_data=0, gnt=0, err=0, defer_cnt=0,
//    rr pointer=0. Pending requests are not remembered. Requesters still holding req are
//    arbitrated normally after reset release.
//  - Latency 1: inputs sampled at edge t; wr_*, gnt and err are valid in cycle t..t+1.
//  - Priority at each edge:
//    1. i2c_we=1: wr_en=1, wr_addr/data = i2c_*, no gnt; rr pointer unchanged.
//       An i2c_addr >= REGCOUNT gives wr_en=0 and no error.
//    2. Otherwise, eligible local reqs are picked round-robin starting at the pointer.
//       Winner i: gnt[i]=1, wr_addr/data = req_*[i], pointer <= (i+1) mod NREQ.
//    3. Otherwise: wr_en=0, wr_addr/wr_data hold their previous values.
//  - Eligible = req[i]=1 AND gnt[i]=0 in the current cycle. The requester is masked on
//    the edge that ends its gnt pulse, so one req pulse yields exactly one grant.
//    Back-to-back grants to one requester are >=2 cycles apart.
//  - Handshake: requester holds req/addr/data stable until it sees gnt, then drops req
//    or presents the next request. Withdrawing req before gnt is legal; no write results.
//  - Protection: winner with req_addr >= REGCOUNT or LOCAL_WMASK[addr]=0 still gets gnt,
//    with err[i]=1 and wr_en=0. The pointer advances as for a normal grant.
//  - defer_cnt: +1 on each edge where i2c_we=1 and at least one local req is eligible.
//    Saturates at 8'hFF; cleared only by reset.
//  - gnt, err and wr_en are never X after reset; gnt is always one-hot or zero.
// STRUCTURE
//  - reg_arb_pkg holds DATA_W=8, the reg_addr_t/reg_data_t typedefs, and a
//    function next_ptr(ptr, NREQ) for mod wrap.
//  - Sub-module rr_pick: combinational round-robin picker
//    (req vector, pointer -> one-hot grant, valid).
//  - The top level holds only the registers: pointer, output stage, defer_cnt.
// TESTING
//  1. Reset release, req=0, i2c_we=0 -> wr_en=0, gnt=0, defer_cnt=0 for 10 cycles;
//     reset asserted mid-grant clears gnt/wr_en at once.
//  2. req[1]=1, addr=5, data=8'hA5 held until gnt -> one cycle later gnt=3'b010, wr_en=1,
//     wr_addr=5, wr_data=8'hA5; exactly one grant although req drops one cycle late.
//  3. req=3'b111 held continuously -> grant order 0,1,2,0,1,2; each requester gets one
//     grant per 3 grant cycles.
//  4. i2c_we=1 (addr 3, data 8'h3C) with req[0]=1 pending -> I2C write first, no gnt,
//     defer_cnt=1; req[0] granted the next edge; 300 such collisions -> defer_cnt=8'hFF.
//  5. LOCAL_WMASK bit 7 = 0, req[2] to addr 7 -> gnt[2]=1, err[2]=1, wr_en=0;
//     an I2C write to addr 7 still commits.
//  6. NREQ=1 and REGCOUNT=20, req to addr 25 -> err; I2C write to addr 25 -> wr_en=0,
//     no err.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
// The bank is 8 bits wide and never deeper than 256 entries, so a single
// 8-bit address type covers every legal configuration for range checks.
package reg_arb_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W_MAX = 8;

  // Saturation value of the deferral counter.
  localparam logic [7:0] DEFER_MAX = 8'hFF;

  typedef logic [DATA_W-1:0]     reg_data_t;
  typedef logic [ADDR_W_MAX-1:0] reg_addr_t;

  // Width of an index able to hold 0..n-1; never narrower than one bit so
  // single-entry configurations still get a real signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin successor of a requester index, wrapping at nreq.
  function automatic int next_ptr(input int ptr, input int nreq);
    return (ptr + 1 >= nreq) ? 0 : ptr + 1;
  endfunction

  // True when the address names a register that exists in the bank.
  function automatic logic addr_in_range(input reg_addr_t addr, input int regcount);
    return int'(addr) < regcount;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Rotates the request vector so the pointer position sits at bit 0, isolates
// the lowest set bit, then rotates the one-hot result back. This keeps the
// search free of variable-index selects and scales cleanly with NREQ.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int PTR_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  logic [2*NREQ-1:0] dbl_req;
  logic [NREQ-1:0]   rot_req;
  logic [NREQ-1:0]   rot_oh;
  logic [2*NREQ-1:0] dbl_oh;

  // Rotate requests so the highest-priority requester lands at bit 0.
  always_comb begin
    dbl_req = {req, req} >> ptr;
    rot_req = dbl_req[NREQ-1:0];
  end

  // Keep only the first requester at or after the pointer.
  always_comb begin
    rot_oh = rot_req & (-rot_req);
  end

  // Undo the rotation: the upper half of the doubled, left-shifted vector
  // holds the winner at its absolute requester position.
  always_comb begin
    dbl_oh = {rot_oh, rot_oh} << ptr;
    grant  = dbl_oh[2*NREQ-1:NREQ];
    valid  = |req;
  end

  // Binary index of the winner, used to advance the pointer.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) idx = PTR_W'(i);
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Single write port arbiter for the shared 8-bit register bank.
// The I2C slave path cannot stall and always owns the port when it strobes;
// local requesters take the remaining cycles in round-robin order.
//
// Local handshake: a requester raises req[i] with req_addr/req_data for slot i
// and holds all three stable until it sees gnt[i] for one cycle. gnt[i] means
// the request is retired (written, or dropped with err[i] if the target is
// out of range or host-owned). The requester may then drop req[i] or present
// a new request; a request still high in the gnt cycle is not granted again,
// so one request yields exactly one grant. Dropping req before gnt is legal.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int                  NREQ        = 3,
  parameter int                  REGCOUNT    = 32,
  parameter logic [REGCOUNT-1:0] LOCAL_WMASK = {REGCOUNT{1'b1}},
  localparam int                 ADDR_W      = idx_width(REGCOUNT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i2c_we,
  input  logic [ADDR_W-1:0]      i2c_addr,
  input  logic [DATA_W-1:0]      i2c_data,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        err,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic [7:0]             defer_cnt
);

  localparam int PTR_W  = idx_width(NREQ);
  localparam int MASK_W = 2 ** ADDR_W;

  // Mask padded to the full address space so any address indexes it safely;
  // the padding bits are never relevant because those addresses fail the
  // range check first.
  localparam logic [MASK_W-1:0] WMASK_FULL = MASK_W'(LOCAL_WMASK);

  logic [PTR_W-1:0]  ptr;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   pick_gnt;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [ADDR_W-1:0] win_addr;
  reg_data_t         win_data;
  logic              win_ok;
  logic              i2c_ok;

  // A requester whose grant pulse is showing right now is not eligible, so a
  // request held one cycle past its grant is not served twice.
  always_comb begin
    elig = req & ~gnt;
  end

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (elig),
    .ptr   (ptr),
    .grant (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Select the winning requester's address and data.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Decide whether each candidate write may reach the bank.
  always_comb begin
    i2c_ok = addr_in_range(reg_addr_t'(i2c_addr), REGCOUNT);
    win_ok = addr_in_range(reg_addr_t'(win_addr), REGCOUNT) && WMASK_FULL[win_addr];
  end

  // Registered output stage: I2C first, then the round-robin winner, else idle
  // with address/data held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      gnt     <= '0;
      err     <= '0;
    end else if (i2c_we) begin
      wr_en   <= i2c_ok;
      wr_addr <= i2c_addr;
      wr_data <= i2c_data;
      gnt     <= '0;
      err     <= '0;
    end else if (pick_valid) begin
      wr_en   <= win_ok;
      wr_addr <= win_addr;
      wr_data <= win_data;
      gnt     <= pick_gnt;
      err     <= win_ok ? '0 : pick_gnt;
    end else begin
      wr_en   <= 1'b0;
      gnt     <= '0;
      err     <= '0;
    end
  end

  // Round-robin pointer: moves past a local winner, untouched by I2C cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (!i2c_we && pick_valid) begin
      ptr <= PTR_W'(next_ptr(int'(pick_idx), NREQ));
    end
  end

  // Count edges where an I2C write pushed back at least one waiting requester.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      defer_cnt <= '0;
    end else if (i2c_we && (|elig) && (defer_cnt != DEFER_MAX)) begin
      defer_cnt <= defer_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: two instances (3 requesters with register 7
// host-owned, and a single requester on a 20-entry bank). Drivers push the
// expected bank/grant response into a queue; monitors pop and compare each
// time a DUT shows activity.
module tb_reg_write_arbiter;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- DUT A: NREQ=3, REGCOUNT=32, reg 7 host-owned ----------------
  logic        i2c_we;
  logic [4:0]  i2c_addr;
  logic [7:0]  i2c_data;
  logic [2:0]  req;
  logic [14:0] req_addr;
  logic [23:0] req_data;
  logic [2:0]  gnt;
  logic [2:0]  err;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  defer_cnt;

  reg_write_arbiter #(
    .NREQ        (3),
    .REGCOUNT    (32),
    .LOCAL_WMASK (32'hFFFF_FF7F)
  ) dut_a (
    .clock     (clock),
    .reset     (reset),
    .i2c_we    (i2c_we),
    .i2c_addr  (i2c_addr),
    .i2c_data  (i2c_data),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .err       (err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .defer_cnt (defer_cnt)
  );

  // ---------------- DUT B: NREQ=1, REGCOUNT=20 ----------------
  logic       b_i2c_we;
  logic [4:0] b_i2c_addr;
  logic [7:0] b_i2c_data;
  logic [0:0] b_req;
  logic [4:0] b_req_addr;
  logic [7:0] b_req_data;
  logic [0:0] b_gnt;
  logic [0:0] b_err;
  logic       b_wr_en;
  logic [4:0] b_wr_addr;
  logic [7:0] b_wr_data;
  logic [7:0] b_defer_cnt;

  reg_write_arbiter #(
    .NREQ     (1),
    .REGCOUNT (20)
  ) dut_b (
    .clock     (clock),
    .reset     (reset),
    .i2c_we    (b_i2c_we),
    .i2c_addr  (b_i2c_addr),
    .i2c_data  (b_i2c_data),
    .req       (b_req),
    .req_addr  (b_req_addr),
    .req_data  (b_req_data),
    .gnt       (b_gnt),
    .err       (b_err),
    .wr_en     (b_wr_en),
    .wr_addr   (b_wr_addr),
    .wr_data   (b_wr_data),
    .defer_cnt (b_defer_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  // {gnt, err, wr_en, wr_addr, wr_data}
  logic [19:0] exp_q[$];
  logic [15:0] exp_q_b[$];
  logic [19:0] got_a, exp_a;
  logic [15:0] got_b, exp_b;

  function automatic logic [19:0] pack_a(input logic [2:0] g, input logic [2:0] e,
                                         input logic en, input logic [4:0] a,
                                         input logic [7:0] d);
    return {g, e, en, a, d};
  endfunction

  function automatic logic [15:0] pack_b(input logic g, input logic e, input logic en,
                                         input logic [4:0] a, input logic [7:0] d);
    return {g, e, en, a, d};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Monitor A: every cycle with grant, error or write activity must match the
  // next expected response.
  always @(negedge clock) begin
    if (reset === 1'b1 && (gnt !== 3'b000 || err !== 3'b000 || wr_en !== 1'b0)) begin
      got_a = {gnt, err, wr_en, wr_addr, wr_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_a unexpected got=%h expected none", got_a);
      end else begin
        exp_a = exp_q.pop_front();
        if (got_a !== exp_a) begin
          errors++;
          $display("FAIL mon_a got=%h expected=%h", got_a, exp_a);
        end
      end
    end
  end

  // Monitor B: same for the single-requester instance.
  always @(negedge clock) begin
    if (reset === 1'b1 && (b_gnt !== 1'b0 || b_err !== 1'b0 || b_wr_en !== 1'b0)) begin
      got_b = {b_gnt, b_err, b_wr_en, b_wr_addr, b_wr_data};
      checks++;
      if (exp_q_b.size() == 0) begin
        errors++;
        $display("FAIL mon_b unexpected got=%h expected none", got_b);
      end else begin
        exp_b = exp_q_b.pop_front();
        if (got_b !== exp_b) begin
          errors++;
          $display("FAIL mon_b got=%h expected=%h", got_b, exp_b);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [7:0] d);
    req_addr[i*5 +: 5] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic i2c_a(input logic we, input logic [4:0] a, input logic [7:0] d);
    i2c_we   = we;
    i2c_addr = a;
    i2c_data = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    i2c_we = 1'b0; i2c_addr = '0; i2c_data = '0;
    req = '0; req_addr = '0; req_data = '0;
    b_i2c_we = 1'b0; b_i2c_addr = '0; b_i2c_data = '0;
    b_req = '0; b_req_addr = '0; b_req_data = '0;

    // Reset values
    repeat (3) tick();
    check("reset_a", 32'({gnt, err, wr_en, wr_addr, wr_data, defer_cnt}), 32'd0);
    check("reset_b", 32'({b_gnt, b_err, b_wr_en, b_wr_addr, b_wr_data, b_defer_cnt}), 32'd0);
    reset = 1'b1;

    // Idle after release
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle", 32'({gnt, wr_en, defer_cnt}), 32'd0);
    end

    // Single request from requester 1, req dropped one cycle late
    req = 3'b010;
    set_req(1, 5'd5, 8'hA5);
    exp_q.push_back(pack_a(3'b010, 3'b000, 1'b1, 5'd5, 8'hA5));
    tick();
    tick();
    req = 3'b000;
    tick();
    tick();
    check("idle_hold", 32'({wr_en, wr_addr, wr_data}), 32'({1'b0, 5'd5, 8'hA5}));

    // Asynchronous reset in the middle of a grant pulse
    req = 3'b001;
    set_req(0, 5'd1, 8'h11);
    @(posedge clock);
    #2;
    check("pre_reset_gnt", 32'(gnt), 32'(3'b001));
    reset = 1'b0;
    #1;
    check("async_reset", 32'({gnt, err, wr_en}), 32'd0);
    req = 3'b000;
    tick();
    reset = 1'b1;
    tick();

    // All three requesting continuously: 0,1,2,0,1,2
    req = 3'b111;
    set_req(0, 5'd1, 8'h10);
    set_req(1, 5'd2, 8'h20);
    set_req(2, 5'd4, 8'h40);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(pack_a(3'b001, 3'b000, 1'b1, 5'd1, 8'h10));
      exp_q.push_back(pack_a(3'b010, 3'b000, 1'b1, 5'd2, 8'h20));
      exp_q.push_back(pack_a(3'b100, 3'b000, 1'b1, 5'd4, 8'h40));
    end
    repeat (6) tick();
    req = 3'b000;
    tick();

    // I2C collides with a pending local request
    i2c_a(1'b1, 5'd3, 8'h3C);
    req = 3'b001;
    set_req(0, 5'd9, 8'h99);
    exp_q.push_back(pack_a(3'b000, 3'b000, 1'b1, 5'd3, 8'h3C));
    exp_q.push_back(pack_a(3'b001, 3'b000, 1'b1, 5'd9, 8'h99));
    tick();
    i2c_a(1'b0, 5'd0, 8'h00);
    check("defer_one", 32'(defer_cnt), 32'd1);
    tick();
    req = 3'b000;
    check("defer_no_inc", 32'(defer_cnt), 32'd1);
    tick();

    // 300 further collisions: counter saturates at 0xFF
    req = 3'b001;
    for (int k = 1; k <= 300; k++) begin
      i2c_a(1'b1, 5'(k % 32), 8'(k));
      exp_q.push_back(pack_a(3'b000, 3'b000, 1'b1, 5'(k % 32), 8'(k)));
      tick();
      if (k == 253) check("defer_fe", 32'(defer_cnt), 32'h0FE);
      if (k == 254) check("defer_ff", 32'(defer_cnt), 32'h0FF);
    end
    i2c_a(1'b0, 5'd0, 8'h00);
    check("defer_sat", 32'(defer_cnt), 32'h0FF);
    exp_q.push_back(pack_a(3'b001, 3'b000, 1'b1, 5'd9, 8'h99));
    tick();
    req = 3'b000;
    tick();
    check("defer_hold", 32'(defer_cnt), 32'h0FF);

    // Local write to host-owned register 7: grant with error, no write
    req = 3'b100;
    set_req(2, 5'd7, 8'h77);
    exp_q.push_back(pack_a(3'b100, 3'b100, 1'b0, 5'd7, 8'h77));
    tick();
    tick();
    req = 3'b000;
    tick();
    // I2C to register 7 is not restricted
    i2c_a(1'b1, 5'd7, 8'hE7);
    exp_q.push_back(pack_a(3'b000, 3'b000, 1'b1, 5'd7, 8'hE7));
    tick();
    i2c_a(1'b0, 5'd0, 8'h00);
    // Neighbouring register 8 is writable locally
    req = 3'b100;
    set_req(2, 5'd8, 8'h88);
    exp_q.push_back(pack_a(3'b100, 3'b000, 1'b1, 5'd8, 8'h88));
    tick();
    tick();
    req = 3'b000;
    tick();

    // DUT B: local write beyond the 20-entry bank
    b_req = 1'b1;
    b_req_addr = 5'd25;
    b_req_data = 8'h5A;
    exp_q_b.push_back(pack_b(1'b1, 1'b1, 1'b0, 5'd25, 8'h5A));
    tick();
    tick();
    b_req = 1'b0;
    tick();
    // I2C beyond the bank: no write and no error
    b_i2c_we = 1'b1;
    b_i2c_addr = 5'd25;
    b_i2c_data = 8'h77;
    tick();
    b_i2c_we = 1'b0;
    check("b_i2c_oor", 32'({b_wr_en, b_err, b_gnt}), 32'd0);
    // Held request on the last register: grants two cycles apart
    b_req = 1'b1;
    b_req_addr = 5'd19;
    b_req_data = 8'h13;
    exp_q_b.push_back(pack_b(1'b1, 1'b0, 1'b1, 5'd19, 8'h13));
    exp_q_b.push_back(pack_b(1'b1, 1'b0, 1'b1, 5'd19, 8'h13));
    repeat (3) tick();
    b_req = 1'b0;
    tick();
    tick();
    // I2C to the last register commits
    b_i2c_we = 1'b1;
    b_i2c_addr = 5'd19;
    b_i2c_data = 8'h9C;
    exp_q_b.push_back(pack_b(1'b0, 1'b0, 1'b1, 5'd19, 8'h9C));
    tick();
    b_i2c_we = 1'b0;
    repeat (4) tick();

    check("queue_a_drained", 32'(exp_q.size()), 32'd0);
    check("queue_b_drained", 32'(exp_q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
